// File: rtl/cart_arb_pkg.sv
// Shared types for the cartridge memory arbiter.
// Requester ids, arbiter states and default read latency.
package cart_arb_pkg;

  typedef enum logic {
    REQ_CPU = 1'b0,
    REQ_PPU = 1'b1
  } req_id_e;

  typedef enum logic {
    ARB_BLOCKED = 1'b0,
    ARB_ACTIVE  = 1'b1
  } arb_state_e;

  localparam int RD_LAT_DEFAULT = 2;

endpackage

// File: rtl/rd_tag_pipe.sv
// Fixed-latency {valid, id} shift register.
// Tracks which requester owns each in-flight read.
module rd_tag_pipe
  import cart_arb_pkg::*;
#(
  parameter int RD_LAT = RD_LAT_DEFAULT
) (
  input  logic clock,
  input  logic reset,
  input  logic flush,
  input  logic in_valid,
  input  logic in_id,
  output logic out_valid,
  output logic out_id
);

  logic [RD_LAT-1:0] valid_q;
  logic [RD_LAT-1:0] valid_d;
  logic [RD_LAT-1:0] id_q;
  logic [RD_LAT-1:0] id_d;

  // shift one stage per cycle; flush kills every valid bit
  always_comb begin
    valid_d    = '0;
    id_d       = '0;
    valid_d[0] = in_valid;
    id_d[0]    = in_id;
    for (int i = 1; i < RD_LAT; i++) begin
      valid_d[i] = valid_q[i-1];
      id_d[i]    = id_q[i-1];
    end
    if (flush) begin
      valid_d = '0;
    end
  end

  // stage registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid_q <= '0;
      id_q    <= '0;
    end else begin
      valid_q <= valid_d;
      id_q    <= id_d;
    end
  end

  assign out_valid = valid_q[RD_LAT-1];
  assign out_id    = id_q[RD_LAT-1];

endmodule

// File: rtl/cart_mem_arbiter.sv
// Round-robin CPU/PPU arbiter for the cartridge memory port.
// Read data is steered back by a fixed-latency tag pipe.
module cart_mem_arbiter
  import cart_arb_pkg::*;
#(
  parameter int RD_LAT = RD_LAT_DEFAULT,
  parameter int ADDR_W = 21
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_ram,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [7:0]        cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [7:0]        cpu_rdata,
  input  logic              ppu_req,
  input  logic              ppu_we,
  input  logic [ADDR_W-1:0] ppu_addr,
  input  logic [7:0]        ppu_wdata,
  output logic              ppu_gnt,
  output logic              ppu_rvalid,
  output logic [7:0]        ppu_rdata,
  input  logic              cart_ready,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_prg_sel,
  output logic              mem_chr_sel,
  output logic              mem_ram_sel,
  output logic              mem_rden,
  output logic              mem_wren,
  output logic [7:0]        mem_write_data,
  input  logic [7:0]        mem_read_data
);

  arb_state_e state_q;
  arb_state_e state_d;
  req_id_e    last_q;
  req_id_e    last_d;

  logic arb_en;
  logic flush;
  logic tag_in_valid;
  logic tag_in_id;
  logic tag_valid;
  logic tag_id;
  logic ret_ok;

  // state follows cart_ready every cycle; grants are allowed in the
  // same cycle cart_ready rises, so arbitration keys off state_d
  always_comb begin
    state_d = cart_ready ? ARB_ACTIVE : ARB_BLOCKED;
    arb_en  = (state_d == ARB_ACTIVE) && !reset;
    flush   = (state_d == ARB_BLOCKED);
  end

  // round-robin grant, issue mux and tag generation
  always_comb begin
    cpu_gnt        = 1'b0;
    ppu_gnt        = 1'b0;
    last_d         = last_q;
    mem_address    = '0;
    mem_prg_sel    = 1'b0;
    mem_chr_sel    = 1'b0;
    mem_ram_sel    = 1'b0;
    mem_rden       = 1'b0;
    mem_wren       = 1'b0;
    mem_write_data = '0;
    tag_in_valid   = 1'b0;
    tag_in_id      = 1'b0;
    if (arb_en) begin
      if (cpu_req && ppu_req) begin
        if (last_q == REQ_CPU) ppu_gnt = 1'b1;
        else                   cpu_gnt = 1'b1;
      end else if (cpu_req) begin
        cpu_gnt = 1'b1;
      end else if (ppu_req) begin
        ppu_gnt = 1'b1;
      end
    end
    unique case (1'b1)
      cpu_gnt: begin
        last_d         = REQ_CPU;
        mem_address    = cpu_addr;
        mem_write_data = cpu_wdata;
        mem_prg_sel    = !cpu_ram;
        mem_ram_sel    = cpu_ram;
        mem_rden       = !cpu_we;
        mem_wren       = cpu_we;
        tag_in_valid   = !cpu_we;
        tag_in_id      = REQ_CPU;
      end
      ppu_gnt: begin
        last_d         = REQ_PPU;
        mem_address    = ppu_addr;
        mem_write_data = ppu_wdata;
        mem_chr_sel    = 1'b1;
        mem_rden       = !ppu_we;
        mem_wren       = ppu_we;
        tag_in_valid   = !ppu_we;
        tag_in_id      = REQ_PPU;
      end
      default: ;
    endcase
  end

  // state and round-robin history
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ARB_BLOCKED;
      last_q  <= REQ_CPU;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

  rd_tag_pipe #(
    .RD_LAT(RD_LAT)
  ) u_tag_pipe (
    .clock    (clock),
    .reset    (reset),
    .flush    (flush),
    .in_valid (tag_in_valid),
    .in_id    (tag_in_id),
    .out_valid(tag_valid),
    .out_id   (tag_id)
  );

  // a cart_ready drop kills the tag reaching the end this very cycle
  always_comb begin
    ret_ok     = tag_valid && cart_ready && !reset &&
                 (state_q == ARB_ACTIVE);
    cpu_rvalid = ret_ok && (tag_id == REQ_CPU);
    ppu_rvalid = ret_ok && (tag_id == REQ_PPU);
    cpu_rdata  = ret_ok ? mem_read_data : 8'h00;
    ppu_rdata  = ret_ok ? mem_read_data : 8'h00;
  end

endmodule

// File: tb/tb_cart_mem_arbiter.sv
// Directed bench for cart_mem_arbiter with a 2-cycle cart_mem model.
// Inputs driven at negedge, outputs sampled 1 time unit later.
module tb_cart_mem_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_ram, cpu_we;
  logic [20:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_gnt, cpu_rvalid;
  logic [7:0]  cpu_rdata;
  logic        ppu_req, ppu_we;
  logic [20:0] ppu_addr;
  logic [7:0]  ppu_wdata;
  logic        ppu_gnt, ppu_rvalid;
  logic [7:0]  ppu_rdata;
  logic        cart_ready;
  logic [20:0] mem_address;
  logic        mem_prg_sel, mem_chr_sel, mem_ram_sel;
  logic        mem_rden, mem_wren;
  logic [7:0]  mem_write_data;
  logic [7:0]  mem_read_data = 8'h00;

  int checks   = 0;
  int failures = 0;

  logic [6:0] strb;
  logic [1:0] rv;
  assign strb = {cpu_gnt, ppu_gnt, mem_prg_sel, mem_chr_sel,
                 mem_ram_sel, mem_rden, mem_wren};
  assign rv   = {cpu_rvalid, ppu_rvalid};

  always #5 clock = ~clock;

  cart_mem_arbiter dut (
    .clock         (clock),
    .reset         (reset),
    .cpu_req       (cpu_req),
    .cpu_ram       (cpu_ram),
    .cpu_we        (cpu_we),
    .cpu_addr      (cpu_addr),
    .cpu_wdata     (cpu_wdata),
    .cpu_gnt       (cpu_gnt),
    .cpu_rvalid    (cpu_rvalid),
    .cpu_rdata     (cpu_rdata),
    .ppu_req       (ppu_req),
    .ppu_we        (ppu_we),
    .ppu_addr      (ppu_addr),
    .ppu_wdata     (ppu_wdata),
    .ppu_gnt       (ppu_gnt),
    .ppu_rvalid    (ppu_rvalid),
    .ppu_rdata     (ppu_rdata),
    .cart_ready    (cart_ready),
    .mem_address   (mem_address),
    .mem_prg_sel   (mem_prg_sel),
    .mem_chr_sel   (mem_chr_sel),
    .mem_ram_sel   (mem_ram_sel),
    .mem_rden      (mem_rden),
    .mem_wren      (mem_wren),
    .mem_write_data(mem_write_data),
    .mem_read_data (mem_read_data)
  );

  // cart_mem model: input register then synchronous read
  // PRG byte = addr^3C, CHR byte = addr^C3, SRAM = stored byte
  logic [7:0]  sram [0:255];
  logic        r1_rd = 1'b0;
  logic [2:0]  r1_sel = 3'b000;
  logic [20:0] r1_addr = '0;
  always @(posedge clock) begin
    if (mem_wren && mem_ram_sel) sram[mem_address[7:0]] <= mem_write_data;
    r1_rd   <= mem_rden;
    r1_sel  <= {mem_prg_sel, mem_chr_sel, mem_ram_sel};
    r1_addr <= mem_address;
    if (r1_rd)
      mem_read_data <= r1_sel[2] ? (r1_addr[7:0] ^ 8'h3C) :
                       r1_sel[1] ? (r1_addr[7:0] ^ 8'hC3) :
                       sram[r1_addr[7:0]];
    else
      mem_read_data <= 8'h00;
  end

  task automatic cyc();
    @(negedge clock);
  endtask

  task automatic test_reset();
    reset = 1'b1; cart_ready = 1'b1;
    cpu_req = 1'b1; ppu_req = 1'b1;
    cpu_ram = 1'b0; cpu_we = 1'b0; ppu_we = 1'b0;
    cpu_addr = 21'h00055; ppu_addr = 21'h00066;
    cpu_wdata = 8'h00; ppu_wdata = 8'h00;
    cyc(); #1;
    checks++;
    if (strb !== 7'b0) begin
      failures++;
      $display("FAIL reset_strobes got=%b exp=%b", strb, 7'b0);
    end
    checks++;
    if ({rv, cpu_rdata, ppu_rdata, mem_address} !== '0) begin
      failures++;
      $display("FAIL reset_data got=%b%h%h%h exp=0",
               rv, cpu_rdata, ppu_rdata, mem_address);
    end
    cyc();
    cpu_req = 1'b0; ppu_req = 1'b0;
    reset = 1'b0;
  endtask

  task automatic test_single_read();
    cyc();
    cpu_req = 1'b1; cpu_ram = 1'b0; cpu_we = 1'b0;
    cpu_addr = 21'h01234;
    #1;
    checks++;
    if (strb !== 7'b1010010) begin
      failures++;
      $display("FAIL single_issue got=%b exp=%b", strb, 7'b1010010);
    end
    checks++;
    if (mem_address !== 21'h01234) begin
      failures++;
      $display("FAIL single_addr got=%h exp=%h", mem_address, 21'h01234);
    end
    cyc(); cpu_req = 1'b0; #1;
    checks++;
    if (rv !== 2'b00) begin
      failures++;
      $display("FAIL single_n1 got=%b exp=%b", rv, 2'b00);
    end
    cyc(); #1;
    checks++;
    if (rv !== 2'b10) begin
      failures++;
      $display("FAIL single_rvalid got=%b exp=%b", rv, 2'b10);
    end
    checks++;
    if (cpu_rdata !== 8'h08) begin
      failures++;
      $display("FAIL single_rdata got=%h exp=%h", cpu_rdata, 8'h08);
    end
    cyc(); #1;
    checks++;
    if (rv !== 2'b00) begin
      failures++;
      $display("FAIL single_n3 got=%b exp=%b", rv, 2'b00);
    end
  endtask

  task automatic test_round_robin();
    logic [1:0] eg;
    logic [1:0] er;
    logic [7:0] ed;
    for (int i = 0; i < 10; i++) begin
      cyc();
      cpu_req = (i < 8); ppu_req = (i < 8);
      cpu_ram = 1'b0; cpu_we = 1'b0; ppu_we = 1'b0;
      cpu_addr = 21'h00040; ppu_addr = 21'h00080;
      #1;
      if (i < 8) begin
        eg = (i % 2 == 0) ? 2'b01 : 2'b10;
        checks++;
        if ({cpu_gnt, ppu_gnt} !== eg) begin
          failures++;
          $display("FAIL rr_gnt[%0d] got=%b exp=%b", i,
                   {cpu_gnt, ppu_gnt}, eg);
        end
      end
      if (i >= 2) begin
        er = ((i - 2) % 2 == 0) ? 2'b01 : 2'b10;
        ed = ((i - 2) % 2 == 0) ? 8'h43 : 8'h7C;
        checks++;
        if (rv !== er) begin
          failures++;
          $display("FAIL rr_rvalid[%0d] got=%b exp=%b", i, rv, er);
        end
        checks++;
        if (cpu_rdata !== ed) begin
          failures++;
          $display("FAIL rr_rdata[%0d] got=%h exp=%h", i, cpu_rdata, ed);
        end
      end
    end
  endtask

  task automatic test_write_readback();
    cyc();
    cpu_req = 1'b1; cpu_ram = 1'b1; cpu_we = 1'b1;
    cpu_addr = 21'h00010; cpu_wdata = 8'h5A;
    #1;
    checks++;
    if (strb !== 7'b1000101) begin
      failures++;
      $display("FAIL wr_issue got=%b exp=%b", strb, 7'b1000101);
    end
    checks++;
    if ({mem_address, mem_write_data} !== {21'h00010, 8'h5A}) begin
      failures++;
      $display("FAIL wr_bus got=%h/%h exp=00010/5a",
               mem_address, mem_write_data);
    end
    cyc(); cpu_we = 1'b0; #1;
    checks++;
    if (strb !== 7'b1000110) begin
      failures++;
      $display("FAIL rb_issue got=%b exp=%b", strb, 7'b1000110);
    end
    cyc(); cpu_req = 1'b0; #1;
    checks++;
    if (rv !== 2'b00) begin
      failures++;
      $display("FAIL wr_no_rvalid got=%b exp=%b", rv, 2'b00);
    end
    cyc(); #1;
    checks++;
    if ({rv, cpu_rdata} !== {2'b10, 8'h5A}) begin
      failures++;
      $display("FAIL rb_data got=%b/%h exp=10/5a", rv, cpu_rdata);
    end
    cpu_ram = 1'b0;
  endtask

  task automatic test_blocked();
    for (int i = 0; i < 3; i++) begin
      cyc();
      cart_ready = 1'b0;
      cpu_req = 1'b1; ppu_req = 1'b1;
      cpu_addr = 21'h00040; ppu_addr = 21'h00080;
      #1;
      checks++;
      if ({strb, rv, mem_address} !== '0) begin
        failures++;
        $display("FAIL blocked[%0d] got=%b/%b/%h exp=0",
                 i, strb, rv, mem_address);
      end
    end
    cyc(); cart_ready = 1'b1; #1;
    checks++;
    if (strb !== 7'b0101010) begin
      failures++;
      $display("FAIL unblock_gnt got=%b exp=%b", strb, 7'b0101010);
    end
    cyc(); cpu_req = 1'b0; ppu_req = 1'b0; #1;
    cyc(); #1;
    checks++;
    if ({rv, ppu_rdata} !== {2'b01, 8'h43}) begin
      failures++;
      $display("FAIL unblock_data got=%b/%h exp=01/43", rv, ppu_rdata);
    end
  endtask

  task automatic test_reload_drop();
    cyc();
    cpu_req = 1'b1; cpu_addr = 21'h00040; #1;
    checks++;
    if (cpu_gnt !== 1'b1) begin
      failures++;
      $display("FAIL drop_gnt0 got=%b exp=1", cpu_gnt);
    end
    cyc();
    cpu_req = 1'b0; ppu_req = 1'b1; ppu_addr = 21'h00080; #1;
    checks++;
    if (ppu_gnt !== 1'b1) begin
      failures++;
      $display("FAIL drop_gnt1 got=%b exp=1", ppu_gnt);
    end
    for (int i = 0; i < 4; i++) begin
      cyc();
      ppu_req = 1'b0;
      cart_ready = (i >= 2);
      #1;
      checks++;
      if (rv !== 2'b00) begin
        failures++;
        $display("FAIL drop_rvalid[%0d] got=%b exp=00", i, rv);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] ed;
    for (int i = 0; i < 5; i++) begin
      cyc();
      cpu_req = (i < 3);
      cpu_addr = 21'(i + 1);
      #1;
      if (i < 3) begin
        checks++;
        if ({cpu_gnt, mem_rden} !== 2'b11) begin
          failures++;
          $display("FAIL b2b_gnt[%0d] got=%b exp=11", i,
                   {cpu_gnt, mem_rden});
        end
      end
      if (i >= 2) begin
        ed = 8'(i - 1) ^ 8'h3C;
        checks++;
        if ({rv, cpu_rdata} !== {2'b10, ed}) begin
          failures++;
          $display("FAIL b2b_data[%0d] got=%b/%h exp=10/%h",
                   i, rv, cpu_rdata, ed);
        end
      end
    end
    cpu_req = 1'b0;
  endtask

  task automatic test_reset_mid();
    cyc();
    ppu_req = 1'b1; ppu_addr = 21'h00080; #1;
    checks++;
    if (ppu_gnt !== 1'b1) begin
      failures++;
      $display("FAIL rstmid_gnt got=%b exp=1", ppu_gnt);
    end
    cyc();
    cpu_req = 1'b1; reset = 1'b1; #1;
    checks++;
    if ({strb, rv, cpu_rdata, ppu_rdata, mem_address} !== '0) begin
      failures++;
      $display("FAIL rstmid_outs got=%b/%b/%h exp=0",
               strb, rv, mem_address);
    end
    cyc();
    reset = 1'b0; cpu_req = 1'b0; ppu_req = 1'b0; #1;
    checks++;
    if (rv !== 2'b00) begin
      failures++;
      $display("FAIL rstmid_drop got=%b exp=00", rv);
    end
    cyc();
    cpu_req = 1'b1; ppu_req = 1'b1; #1;
    checks++;
    if ({cpu_gnt, ppu_gnt} !== 2'b01) begin
      failures++;
      $display("FAIL rstmid_last got=%b exp=01", {cpu_gnt, ppu_gnt});
    end
    cyc(); cpu_req = 1'b0; ppu_req = 1'b0;
    cyc(); cyc();
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_round_robin();
    test_write_readback();
    test_blocked();
    test_reload_drop();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cart_mem_arbiter.md
# cart_mem_arbiter

Shares the single cartridge memory port between the CPU (PRG ROM / cart SRAM) and the PPU (CHR) requesters. It sits between the CPU/PPU bus glue and `cart_mem`. It grants at most one access per cycle, using round-robin selection. Read data is returned to the correct requester through a fixed-latency tag pipeline, and all traffic is blocked while the cartridge is not loaded.

## Interface
Parameters:
- `RD_LAT`, 2: cycles from issue to valid `mem_read_data` (`cart_mem` has an input register plus a synchronous SPRAM read).
- `ADDR_W`, 21: width of the requester and memory address.

Ports:
- `clock` in 1: the single clock.
- `reset` in 1: asynchronous, active-high.
- `cpu_req` in 1: CPU access request; held stable until `cpu_gnt`.
- `cpu_ram` in 1: 0 selects PRG, 1 selects cart SRAM.
- `cpu_we` in 1: write when 1.
- `cpu_addr` in `ADDR_W`: CPU address.
- `cpu_wdata` in 8: CPU write data.
- `cpu_gnt` out 1: request accepted this cycle.
- `cpu_rvalid` out 1: `cpu_rdata` is valid.
- `cpu_rdata` out 8: CPU read data.
- `ppu_req` in 1: PPU access request (CHR only); same holding rule as CPU.
- `ppu_we` in 1: write when 1.
- `ppu_addr` in `ADDR_W`: PPU address.
- `ppu_wdata` in 8: PPU write data.
- `ppu_gnt` out 1: request accepted this cycle.
- `ppu_rvalid` out 1: `ppu_rdata` is valid.
- `ppu_rdata` out 8: PPU read data.
- `cart_ready` in 1: load complete, from `cart_mem`.
- `mem_address` out `ADDR_W`: to `cart_mem`.
- `mem_prg_sel` out 1: to `cart_mem`.
- `mem_chr_sel` out 1: to `cart_mem`.
- `mem_ram_sel` out 1: to `cart_mem`.
- `mem_rden` out 1: to `cart_mem`.
- `mem_wren` out 1: to `cart_mem`.
- `mem_write_data` out 8: to `cart_mem`.
- `mem_read_data` in 8: from `cart_mem`.

## Operation
- States:
  - BLOCKED is the reset state and is entered whenever `cart_ready`=0.
  - ACTIVE is entered when `cart_ready`=1.
  - The transition is evaluated every cycle.
- In BLOCKED:
  - No grants are issued.
  - All `mem_*` strobes and selects are 0.
  - The tag pipeline is cleared, so no `rvalid` is produced.
- In ACTIVE, arbitration is combinational on the current `req` inputs:
  - If only one requester is asserting `req`, that requester is granted.
  - If both are asserting `req`, the requester not granted last is granted.
  - The `last` register resets to CPU, so the PPU wins the first tie.
- Grant and issue are the same cycle:
  - The selected requester's `addr`, `wdata` and `we` drive the `mem_*` outputs.
  - The matching select is asserted: `prg_sel` or `ram_sel` for the CPU, `chr_sel` for the PPU.
  - `mem_rden`=!`we` and `mem_wren`=`we`.
  - Exactly one select is high, and only when a grant is issued.
- Tag pipeline:
  - It is `RD_LAT` stages of {valid, id}.
  - Stage 0 is loaded with {`gnt`&&!`we`, granted id} every cycle.
  - At the last stage, `mem_read_data` is routed to both `rdata` outputs.
  - The `rvalid` of the matching id pulses for one cycle.
- Writes produce no `rvalid`.
- Back-to-back grants to the same requester are allowed when the other is idle, giving full throughput of 1 access per cycle.

## Timing
- Grant on cycle N causes `rvalid`/`rdata` on cycle N+`RD_LAT` (N+2 by default).
- Fairness: with both requesters continuously asserting `req`, grants strictly alternate. Worst-case wait is 1 cycle.
- Reset values of outputs: `gnt`=0, `rvalid`=0, `rdata`=0, all `mem_*`=0.
- Reset values of internal state: `last`=CPU, pipeline valid bits=0.
- Falling edge of `cart_ready` (reload) mid-operation:
  - All in-flight read tags are dropped in the same cycle, so no `rvalid` is raised for them.
  - Requesters must re-issue after `cart_ready` returns.
- When `cart_ready` rises, a grant is possible in that same cycle.
- A requester dropping `req` before `gnt` is legal; no access is issued for it.
- Asynchronous reset mid-read drops the pending `rvalid`.

## Structure
- Package `cart_arb_pkg`, holding:
  - the requester id enum (`REQ_CPU`, `REQ_PPU`);
  - the state enum (`ARB_BLOCKED`, `ARB_ACTIVE`);
  - `RD_LAT_DEFAULT`.
- One sub-module: `rd_tag_pipe`, a parameterised `RD_LAT`-deep shift register of {valid, id} with a synchronous flush input.

## Test plan
- Single CPU PRG read at `0x01234` while `cart_ready`=1 -> `mem_prg_sel`=1 and `mem_rden`=1 on cycle N; `cpu_rvalid` on N+2 with the memory model byte; `ppu_rvalid` stays 0.
- Both requesters asserting `req` continuously for 8 cycles (CPU reads, PPU reads) -> grants alternate PPU, CPU, PPU, …; the `rdata` id sequence matches the grant order, 2 cycles later.
- CPU write of `0x5A` to SRAM `0x0010` followed by a read back of the same address -> `mem_ram_sel`=1 and `mem_wren`=1 for the write, with no `rvalid`; the read returns `0x5A`.
- `cart_ready`=0 with both requesters asserting `req` -> no `gnt` and all `mem_*`=0; when `cart_ready` rises, the PPU is granted first.
- Issue two reads, then drop `cart_ready` 1 cycle later -> neither `rvalid` fires.
- Assert `reset` mid-stream -> all outputs go to 0 immediately; after release, `last`=CPU.
